// File: rtl/jpeg_cone_capture_misr.sv
// Capture stage for a single-output jpeg timing cone: compacts SAMPLES accepted bits into a serial
// MISR signature and hands it off over valid/ready. Optional sig_parity output under CAPTURE_PARITY_EN.
module jpeg_cone_capture_misr #(
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'h0000,
    parameter int               SAMPLES = 256,
    parameter int               CNT_W   = $clog2(SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [SIG_W-1:0] sig_data,
    output logic [CNT_W-1:0] sample_cnt,
`ifdef CAPTURE_PARITY_EN
    output logic             sig_parity,
`endif
    output logic             dropped
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_p0;
    logic [SIG_W-1:0]   sig_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic               vld_p0;
    logic               rdy_p0;
    logic               drop_p0;
    logic               par_p0;

    // One serial MISR step: shift left, fold the feedback bit in through the tap mask.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic b);
        logic fb;
        fb = s[SIG_W-1] ^ b;
        misr_step = {s[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // Stage p0: signature, counter and handshake state all update together on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= ACCUM;
            sig_p0   <= SEED;
            cnt_p0   <= '0;
            vld_p0   <= 1'b0;
            rdy_p0   <= 1'b1;
            drop_p0  <= 1'b0;
            par_p0   <= 1'b0;
        end else begin
            case (state_p0)
                ACCUM: begin
                    if (in_valid && rdy_p0) begin
                        sig_p0 <= misr_step(sig_p0, in_bit);
                        cnt_p0 <= cnt_p0 + CNT_W'(1);
                        par_p0 <= par_p0 ^ in_bit;
                        if (cnt_p0 == CNT_W'(SAMPLES - 1)) begin
                            state_p0 <= HOLD;
                            vld_p0   <= 1'b1;
                            rdy_p0   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // Bits arriving while the signature waits are discarded but remembered.
                    if (in_valid) drop_p0 <= 1'b1;
                    if (vld_p0 && sig_ready) begin
                        state_p0 <= ACCUM;
                        sig_p0   <= SEED;
                        cnt_p0   <= '0;
                        vld_p0   <= 1'b0;
                        rdy_p0   <= 1'b1;
                        par_p0   <= 1'b0;
                    end
                end
                default: state_p0 <= ACCUM;
            endcase
        end
    end

    assign in_ready   = rdy_p0;
    assign sig_valid  = vld_p0;
    assign sig_data   = sig_p0;
    assign sample_cnt = cnt_p0;
    assign dropped    = drop_p0;
`ifdef CAPTURE_PARITY_EN
    assign sig_parity = par_p0;
`else
    logic unused_par;
    assign unused_par = par_p0;
`endif

endmodule

// File: tb/tb_jpeg_cone_capture_misr.sv
// Directed bench for jpeg_cone_capture_misr (SIG_W=4, POLY=3, SEED=0; SAMPLES=4 and SAMPLES=1 instances).
module tb_jpeg_cone_capture_misr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_in_valid, a_in_bit, a_in_ready, a_sig_valid, a_sig_ready, a_dropped;
    logic [3:0] a_sig_data;
    logic [2:0] a_sample_cnt;
    logic       b_in_valid, b_in_bit, b_in_ready, b_sig_valid, b_sig_ready, b_dropped;
    logic [3:0] b_sig_data;
    logic [0:0] b_sample_cnt;
`ifdef CAPTURE_PARITY_EN
    logic       a_sig_parity, b_sig_parity;
`endif

    int checks = 0;
    int failures = 0;

    jpeg_cone_capture_misr #(.SIG_W(4), .POLY(4'h3), .SEED(4'h0), .SAMPLES(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_bit(a_in_bit), .in_ready(a_in_ready),
        .sig_valid(a_sig_valid), .sig_ready(a_sig_ready), .sig_data(a_sig_data),
        .sample_cnt(a_sample_cnt),
`ifdef CAPTURE_PARITY_EN
        .sig_parity(a_sig_parity),
`endif
        .dropped(a_dropped)
    );

    jpeg_cone_capture_misr #(.SIG_W(4), .POLY(4'h3), .SEED(4'h0), .SAMPLES(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_bit(b_in_bit), .in_ready(b_in_ready),
        .sig_valid(b_sig_valid), .sig_ready(b_sig_ready), .sig_data(b_sig_data),
        .sample_cnt(b_sample_cnt),
`ifdef CAPTURE_PARITY_EN
        .sig_parity(b_sig_parity),
`endif
        .dropped(b_dropped)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one falling edge later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed_a(input logic b);
        a_in_valid = 1'b1;
        a_in_bit   = b;
        step();
        a_in_valid = 1'b0;
        a_in_bit   = 1'b0;
    endtask

    task automatic handoff_a();
        a_sig_ready = 1'b1;
        step();
        a_sig_ready = 1'b0;
    endtask

    logic [3:0] exp1 [4] = '{4'h3, 4'h6, 4'hC, 4'hB};
    logic [3:0] bits1 = 4'b0001;
    logic [6:0] gap_vld = 7'b1100101;
    logic [6:0] gap_bit = 7'b0011011;
    logic [3:0] gap_exp [7] = '{4'h3, 4'h3, 4'h6, 4'h6, 4'h6, 4'hC, 4'hB};

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_bit = 0; a_sig_ready = 0;
        b_in_valid = 0; b_in_bit = 0; b_sig_ready = 0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_sig_valid", a_sig_valid, 0);
        chk("rst_cnt", a_sample_cnt, 0);
        chk("rst_dropped", a_dropped, 0);
        chk("rst_sig", a_sig_data, 0);

        // Scenario 1: 1,0,0,0 back to back.
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_bit   = bits1[i];
            step();
            chk("s1_sig", a_sig_data, exp1[i]);
            chk("s1_cnt", a_sample_cnt, i + 1);
            chk("s1_valid", a_sig_valid, (i == 3) ? 1 : 0);
        end
        a_in_valid = 1'b0;
        a_in_bit   = 1'b0;
        chk("s1_in_ready", a_in_ready, 0);
`ifdef CAPTURE_PARITY_EN
        chk("s1_parity", a_sig_parity, 1);
`endif
        handoff_a();
        chk("s1_ho_valid", a_sig_valid, 0);
        chk("s1_ho_ready", a_in_ready, 1);
        chk("s1_ho_cnt", a_sample_cnt, 0);
        chk("s1_ho_sig", a_sig_data, 0);

        // Scenario 2: zeros, then a stalled collector.
        for (int i = 0; i < 4; i++) feed_a(1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s2_valid", a_sig_valid, 1);
            chk("s2_sig", a_sig_data, 0);
            chk("s2_in_ready", a_in_ready, 0);
        end

        // Scenario 3: drop in HOLD, then handoff keeps dropped sticky.
        feed_a(1'b1);
        chk("s3_dropped", a_dropped, 1);
        chk("s3_sig", a_sig_data, 0);
        chk("s3_cnt", a_sample_cnt, 4);
        handoff_a();
        chk("s3_ho_cnt", a_sample_cnt, 0);
        chk("s3_ho_sig", a_sig_data, 0);
        chk("s3_ho_dropped", a_dropped, 1);
        chk("s3_ho_ready", a_in_ready, 1);

        // Scenario 4: gaps with in_bit=1 while in_valid is low.
        for (int i = 0; i < 7; i++) begin
            a_in_valid = gap_vld[i];
            a_in_bit   = gap_bit[i];
            step();
            chk("s4_sig", a_sig_data, gap_exp[i]);
        end
        a_in_valid = 1'b0;
        a_in_bit   = 1'b0;
        chk("s4_valid", a_sig_valid, 1);
        chk("s4_cnt", a_sample_cnt, 4);
`ifdef CAPTURE_PARITY_EN
        chk("s4_parity", a_sig_parity, 1);
`endif
        handoff_a();

        // Scenario 5: reset mid-signature beats a concurrent accept.
        feed_a(1'b1);
        feed_a(1'b0);
        chk("s5_pre_sig", a_sig_data, 4'h6);
        chk("s5_pre_cnt", a_sample_cnt, 2);
        rst = 1'b1;
        a_in_valid = 1'b1;
        a_in_bit   = 1'b1;
        step();
        rst = 1'b0;
        a_in_valid = 1'b0;
        a_in_bit   = 1'b0;
        chk("s5_rst_sig", a_sig_data, 0);
        chk("s5_rst_cnt", a_sample_cnt, 0);
        chk("s5_rst_valid", a_sig_valid, 0);
        chk("s5_rst_dropped", a_dropped, 0);
        for (int i = 0; i < 4; i++) feed_a(bits1[i]);
        chk("s5_sig", a_sig_data, 4'hB);
        chk("s5_valid", a_sig_valid, 1);

        // Scenario 6: SAMPLES=1 with collector always ready.
        b_sig_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_bit    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("s6_valid", b_sig_valid, (i % 2 == 0) ? 1 : 0);
            chk("s6_sig", b_sig_data, (i % 2 == 0) ? 4'h3 : 4'h0);
            chk("s6_in_ready", b_in_ready, (i % 2 == 0) ? 0 : 1);
`ifdef CAPTURE_PARITY_EN
            chk("s6_parity", b_sig_parity, (i % 2 == 0) ? 1 : 0);
`endif
        end
        b_in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
